// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-bus responder: MMIO register map, status bits,
// region decode type and a byte-lane merge helper.
package dmem_resp_pkg;

  localparam logic [5:0] OFF_MTIME_LO    = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI    = 6'h04;
  localparam logic [5:0] OFF_MTIMECMP_LO = 6'h08;
  localparam logic [5:0] OFF_MTIMECMP_HI = 6'h0C;
  localparam logic [5:0] OFF_CON_TX      = 6'h10;
  localparam logic [5:0] OFF_CON_STAT    = 6'h14;

  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_NONZERO = 3;
  localparam int STAT_OVF     = 4;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] result;
    for (int i = 0; i < 4; i++)
      result[i*8 +: 8] = byteen[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return result;
  endfunction

endpackage

// File: rtl/dmem_bus_responder_fifo.sv
// Synchronous FIFO with occupancy count; head is zero while empty.
// A push while full is only taken when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Data-bus responder: on-chip RAM plus MMIO timer and console TX FIFO, zero-wait reads.
// Optional registered bus_fault output when DMEM_RESP_FAULT_EN is defined.
module dmem_bus_responder
  import dmem_resp_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_addr,
  input  logic [WIDTH-1:0] bus_data_in,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [3:0]       bus_byteen,
  output logic [WIDTH-1:0] bus_data_out,
  output logic             timer_irq,
`ifdef DMEM_RESP_FAULT_EN
  output logic             bus_fault,
`endif
  output logic             con_valid,
  output logic [7:0]       con_data,
  input  logic             con_ready
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  region_t           region;
  logic [5:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0][7:0]   ram [RAM_WORDS];
  logic [31:0]       mtime_lo, mtime_hi, mtimecmp_lo, mtimecmp_hi;
  logic              mmio_we, wr_con_tx, wr_con_stat, tx_push_req, con_pop;
  logic              fifo_full, fifo_empty, overflow;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       stat_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];
  assign mmio_off = {bus_addr[5:2], 2'b00};
  assign ram_idx  = bus_addr[RAM_AW+1:2];

  // RAM takes priority should a small MMIO_BASE ever overlap the RAM window
  always_comb begin
    if (bus_addr[WIDTH-1:RAM_AW+2] == '0)                  region = REG_RAM;
    else if (bus_addr[WIDTH-1:6] == MMIO_BASE[WIDTH-1:6])  region = REG_MMIO;
    else                                                   region = REG_NONE;
  end

  assign mmio_we     = bus_we && (region == REG_MMIO);
  assign wr_con_tx   = mmio_we && (mmio_off == OFF_CON_TX);
  assign wr_con_stat = mmio_we && (mmio_off == OFF_CON_STAT);
  assign tx_push_req = wr_con_tx && bus_byteen[0];

  always_ff @(posedge clk) begin
    if (bus_we && (region == REG_RAM))
      for (int i = 0; i < 4; i++)
        if (bus_byteen[i]) ram[ram_idx][i] <= bus_data_in[i*8 +: 8];
  end

  // A written half takes the bus value; the other half still counts, with HI
  // taking the carry out of the pre-write LO value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_lo    <= '0;
      mtime_hi    <= '0;
      mtimecmp_lo <= '1;
      mtimecmp_hi <= '1;
      timer_irq   <= 1'b0;
    end else begin
      timer_irq <= {mtime_hi, mtime_lo} >= {mtimecmp_hi, mtimecmp_lo};
      if (mmio_we && mmio_off == OFF_MTIME_LO)
        mtime_lo <= merge_bytes(mtime_lo, bus_data_in, bus_byteen);
      else
        mtime_lo <= mtime_lo + 32'd1;
      if (mmio_we && mmio_off == OFF_MTIME_HI)
        mtime_hi <= merge_bytes(mtime_hi, bus_data_in, bus_byteen);
      else
        mtime_hi <= mtime_hi + {31'd0, &mtime_lo};
      if (mmio_we && mmio_off == OFF_MTIMECMP_LO)
        mtimecmp_lo <= merge_bytes(mtimecmp_lo, bus_data_in, bus_byteen);
      if (mmio_we && mmio_off == OFF_MTIMECMP_HI)
        mtimecmp_hi <= merge_bytes(mtimecmp_hi, bus_data_in, bus_byteen);
    end
  end

  assign con_valid = !fifo_empty;
  assign con_pop   = con_valid && con_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_req),
    .pop   (con_pop),
    .din   (bus_data_in[7:0]),
    .head  (con_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (tx_push_req && fifo_full && !con_pop)
      overflow <= 1'b1;
    else if (wr_con_stat && bus_byteen[0] && bus_data_in[STAT_OVF])
      overflow <= 1'b0;
  end

`ifdef DMEM_RESP_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus_fault <= 1'b0;
    else
      bus_fault <= ((bus_we || bus_re) && (region == REG_NONE)) ||
                   ((wr_con_tx || wr_con_stat) && (bus_byteen == 4'b0000));
  end
`endif

  always_comb begin
    stat_word               = '0;
    stat_word[STAT_OVF]     = overflow;
    stat_word[STAT_NONZERO] = (fifo_count != '0);
    stat_word[STAT_EMPTY]   = fifo_empty;
    stat_word[STAT_FULL]    = fifo_full;
    bus_data_out = '0;
    if (bus_re) begin
      case (region)
        REG_RAM:  bus_data_out = ram[ram_idx];
        REG_MMIO: begin
          case (mmio_off)
            OFF_MTIME_LO:    bus_data_out = mtime_lo;
            OFF_MTIME_HI:    bus_data_out = mtime_hi;
            OFF_MTIMECMP_LO: bus_data_out = mtimecmp_lo;
            OFF_MTIMECMP_HI: bus_data_out = mtimecmp_hi;
            OFF_CON_STAT:    bus_data_out = stat_word;
            default:         bus_data_out = '0;
          endcase
        end
        default:  bus_data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Self-checking bench for dmem_bus_responder: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the bus responder.
module tb_dmem_bus_responder;
  localparam logic [31:0] MMIO  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr = '0, bus_data_in = '0, bus_data_out;
  logic        bus_we = 1'b0, bus_re = 1'b0, con_ready = 1'b0;
  logic [3:0]  bus_byteen = '0;
  logic        timer_irq, con_valid;
  logic [7:0]  con_data;
`ifdef DMEM_RESP_FAULT_EN
  logic        bus_fault;
`endif

  dmem_bus_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_addr     (bus_addr),
    .bus_data_in  (bus_data_in),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_byteen   (bus_byteen),
    .bus_data_out (bus_data_out),
    .timer_irq    (timer_irq),
`ifdef DMEM_RESP_FAULT_EN
    .bus_fault    (bus_fault),
`endif
    .con_valid    (con_valid),
    .con_data     (con_data),
    .con_ready    (con_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_time, m_cmp;
  logic        m_irq, m_ovf, m_fault;
  logic [7:0]  m_q[$];
  logic [31:0] m_ram [32];

  logic [31:0] last_rdata;
  logic [7:0]  last_cdata;
  logic        last_irq, last_fault;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic is_ram(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic logic is_mmio(input logic [31:0] a);
    return !is_ram(a) && (a[31:6] == MMIO[31:6]);
  endfunction

  function automatic logic [31:0] model_read(input logic re, input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (!re) return 32'd0;
    if (is_ram(w)) return (w < 32'd128) ? m_ram[w[6:2]] : 32'd0;
    if (!is_mmio(w)) return 32'd0;
    case (w[5:0])
      6'h00:   return m_time[31:0];
      6'h04:   return m_time[63:32];
      6'h08:   return m_cmp[31:0];
      6'h0C:   return m_cmp[63:32];
      6'h14:   return {27'd0, m_ovf, m_q.size() != 0, m_q.size() == 0, m_q.size() == DEPTH, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_time = '0; m_cmp = '1; m_irq = 1'b0; m_ovf = 1'b0; m_fault = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic rdy);
    logic [31:0] w;
    logic [63:0] nt;
    logic        popped, push_req, was_full;
    w        = {a[31:2], 2'b00};
    nt       = m_time + 64'd1;
    popped   = (m_q.size() != 0) && rdy;
    was_full = (m_q.size() == DEPTH);
    push_req = 1'b0;
    m_fault  = ((we || re) && !is_ram(w) && !is_mmio(w)) ||
               (we && is_mmio(w) && (w[5:0] == 6'h10 || w[5:0] == 6'h14) && be == 4'b0000);
    m_irq    = (m_time >= m_cmp);
    if (we && is_ram(w) && w < 32'd128) m_ram[w[6:2]] = lanes(m_ram[w[6:2]], d, be);
    if (we && is_mmio(w)) begin
      case (w[5:0])
        6'h00: nt[31:0]   = lanes(m_time[31:0], d, be);
        6'h04: nt[63:32]  = lanes(m_time[63:32], d, be);
        6'h08: m_cmp[31:0]  = lanes(m_cmp[31:0], d, be);
        6'h0C: m_cmp[63:32] = lanes(m_cmp[63:32], d, be);
        6'h10: push_req = be[0];
        6'h14: if (be[0] && d[4]) m_ovf = 1'b0;
        default: ;
      endcase
    end
    if (popped) void'(m_q.pop_front());
    if (push_req) begin
      if (!was_full || popped) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    m_time = nt;
  endtask

  // One bus cycle: drive, compare at the falling edge, advance model and DUT.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be, input logic rdy);
    bus_we = we; bus_re = re; bus_addr = a; bus_data_in = d; bus_byteen = be; con_ready = rdy;
    @(negedge clk);
    last_rdata = bus_data_out;
    last_cdata = con_data;
    last_irq   = timer_irq;
    checkOutput("rdata", bus_data_out, model_read(re, a));
    checkOutput("timer_irq", 32'(timer_irq), 32'(m_irq));
    checkOutput("con_valid", 32'(con_valid), 32'(m_q.size() != 0));
    checkOutput("con_data", 32'(con_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
`ifdef DMEM_RESP_FAULT_EN
    last_fault = bus_fault;
    checkOutput("bus_fault", 32'(bus_fault), 32'(m_fault));
`else
    last_fault = 1'b0;
`endif
    model_step(we, re, a, d, be, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, rdy);
  endtask

  initial begin
    int rise_idx;
    model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = '0;
    @(posedge clk); #1;
    checkOutput("reset_con_valid", 32'(con_valid), 32'd0);
    checkOutput("reset_con_data", 32'(con_data), 32'd0);
    checkOutput("reset_irq", 32'(timer_irq), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) idle(1'b0);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h00, 32'd0, 4'b0000, 1'b0);
    checkOutput("mtime_after_reset", last_rdata, 32'd5);

    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 32'(i * 4), $urandom, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'd0, 4'b0000, 1'b0);
    checkOutput("ram_byteen", last_rdata, 32'h00AD_00EF);

    applyStimulus(1'b1, 1'b0, MMIO | 32'h04, 32'd0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h00, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h04, 32'd0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h00, 32'd0, 4'b0000, 1'b0);
    checkOutput("carry_lo", last_rdata, 32'd0);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h04, 32'd0, 4'b0000, 1'b0);
    checkOutput("carry_hi", last_rdata, 32'd1);

    applyStimulus(1'b1, 1'b0, MMIO | 32'h04, 32'd0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h0C, 32'd0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h08, 32'd100, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h00, 32'd95, 4'b1111, 1'b0);
    rise_idx = -1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      if (last_irq && rise_idx < 0) rise_idx = i;
    end
    checkOutput("irq_rise_cycle", 32'(rise_idx), 32'd6);
    checkOutput("irq_held", 32'(last_irq), 32'd1);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h0C, 32'hFFFF_FFFF, 4'b1111, 1'b0);

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, MMIO | 32'h10, 32'hA0 + 32'(i), 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h14, 32'd0, 4'b0000, 1'b0);
    checkOutput("stat_full_ovf", last_rdata, 32'h0000_001A);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      checkOutput("drain_order", 32'(last_cdata), 32'hA0 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, MMIO | 32'h14, 32'd0, 4'b0000, 1'b1);
    checkOutput("stat_drained", last_rdata, 32'h0000_0014);
    applyStimulus(1'b1, 1'b0, MMIO | 32'h14, 32'h10, 4'b1111, 1'b1);
    applyStimulus(1'b0, 1'b1, MMIO | 32'h14, 32'd0, 4'b0000, 1'b1);
    checkOutput("stat_ovf_clear", last_rdata, 32'h0000_0004);

    applyStimulus(1'b0, 1'b1, 32'h2000_0000, 32'd0, 4'b0000, 1'b0);
    checkOutput("unmapped_read", last_rdata, 32'd0);
    idle(1'b0);
`ifdef DMEM_RESP_FAULT_EN
    checkOutput("fault_pulse", 32'(last_fault), 32'd1);
    idle(1'b0);
    checkOutput("fault_clear", 32'(last_fault), 32'd0);
`endif

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, MMIO | 32'h10, 32'h55 + 32'(i), 4'b0001, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_con_valid", 32'(con_valid), 32'd0);
    checkOutput("midreset_con_data", 32'(con_data), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    idle(1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      logic        we, re, rdy;
      d   = $urandom;
      be  = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      we  = 1'b0; re = 1'b0; a = 32'd0;
      case ($urandom_range(0, 5))
        0: begin we = 1'b1; re = 1'($urandom); a = 32'($urandom_range(0, 127)); end
        1: begin re = 1'b1; a = 32'($urandom_range(0, 127)); end
        2: begin
          we = 1'($urandom); re = 1'($urandom);
          a  = MMIO | 32'($urandom_range(0, 63));
          if (a[5:2] == 4'd5) be = 4'b1111;
        end
        3: begin
          we = 1'b1; a = MMIO | 32'h10;
          if ($urandom_range(0, 3) != 0) be[0] = 1'b1;
        end
        4: begin we = 1'($urandom); re = !we || 1'($urandom); a = 32'h2000_0000 + $urandom_range(0, 32'h0FFF_FFFF); end
        default: ;
      endcase
      applyStimulus(we, re, a, d, be, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_responder.md
Name: dmem_bus_responder

Overview:
Responder end of the core's data bus. Decodes each bus access into an on-chip data RAM or a small MMIO block: a 64-bit cycle timer with compare interrupt, and a console TX FIFO drained by an external ready/valid sink. Reads return in the same cycle, so the single-cycle core needs no stall. Writes commit on the rising clock edge.

Parameters:
WIDTH, 32, bus data/address width (only 32 supported)
RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two)
MMIO_BASE, 32'h1000_0000, base address of the MMIO block (64-byte aligned)
FIFO_DEPTH, 8, console TX FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
bus_addr  in  WIDTH  byte address from core
bus_data_in  in  WIDTH  write data from core, byte lanes already positioned
bus_we  in  1  write strobe
bus_re  in  1  read strobe
bus_byteen  in  4  byte-lane enables for writes
bus_data_out  out  WIDTH  read data to core (combinational)
timer_irq  out  1  registered, level: mtime >= mtimecmp
con_valid  out  1  FIFO head valid
con_data  out  8  FIFO head byte
con_ready  in  1  sink accepts head this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Decode uses bus_addr[1:0] ignored (word-aligned).
  - RAM hit: addr < RAM_WORDS*4.
  - MMIO hit: addr[31:6] == MMIO_BASE[31:6].
  - Anything else is unmapped: reads return 0, writes are dropped.
- Read data:
  - bus_data_out = selected word when bus_re=1, otherwise 0. Purely combinational from the current-cycle state.
  - If bus_we and bus_re are both 1, the read returns the pre-write value.
- RAM:
  - Write on posedge when bus_we=1. Only lanes with bus_byteen[i]=1 are written.
  - RAM contents are not reset.
- MMIO offsets (word):
  - 0x00 MTIME_LO, 0x04 MTIME_HI: R/W.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI: R/W.
  - 0x10 CON_TX: write pushes byte [7:0]; read returns 0.
  - 0x14 CON_STAT: read {27'b0, overflow, count-is-nonzero, empty, full, 1'b0}; writing bit4=1 clears overflow.
- mtime:
  - 64-bit, increments by 1 every cycle, wrapping at 2^64-1 to 0. Carry from LO propagates to HI in the same cycle.
  - A write to either half replaces the byte-enabled lanes of that half. The write wins over the increment for that cycle; the other half keeps normal increment/carry behaviour.
- mtimecmp:
  - Byte-enabled writes.
  - Reset value is all ones, so timer_irq=0 after reset.
- timer_irq:
  - Flop of (mtime >= mtimecmp), unsigned 64-bit compare of the current register values. One cycle of latency after the condition arises.
- Console FIFO:
  - con_valid = !empty; con_data = head.
  - Pop when con_valid && con_ready.
  - Push on a write to CON_TX with bus_byteen[0]=1.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Push while full without a pop: byte dropped, overflow set (sticky).
  - Push and pop together while empty: push only (con_valid was 0). Head appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count has log2(FIFO_DEPTH)+1 bits.
- Reset values:
  - mtime=0, mtimecmp=all ones, timer_irq=0.
  - FIFO empty, con_valid=0, con_data=0, overflow=0.
  - bus_data_out=0 while bus_re=0.
  - Reset asserted mid-operation discards in-flight FIFO contents immediately.

Optional Feature:
DMEM_RESP_FAULT_EN
- Defined:
  - Adds output bus_fault (1 bit, registered, reset 0).
  - bus_fault is set for one cycle after any access (we or re) that is unmapped, or a write to CON_TX/CON_STAT with bus_byteen==0.
  - Behaviour of the access itself is unchanged.
- Undefined: no bus_fault port; unmapped accesses are silently ignored.

Decomposition:
- Package dmem_resp_pkg:
  - MMIO offset localparams (OFF_MTIME_LO … OFF_CON_STAT) and CON_STAT bit indices.
  - Region-select enum region_t {REG_RAM, REG_MMIO, REG_NONE}.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH), with push/pop/full/empty/count ports. The FIFO is instantiated once.
- RAM stays inline as a byte-lane array.

Test Plan:
- Reset release, idle 5 cycles, then read MTIME_LO -> a small nonzero cycle count matching the cycles since release; timer_irq=0; con_valid=0.
- Write 0xDEADBEEF to RAM 0x40 with byteen=4'b0101, then read -> 0x00AD00EF (prior contents 0).
- Write MTIME_LO=0xFFFFFFFF and MTIME_HI=0; next cycle read HI -> 1, LO -> 0x00000000 (carry).
- Write MTIMECMP={0,100}, MTIME=95 -> timer_irq rises exactly one cycle after mtime reaches 100 and stays high.
- con_ready=0, push 9 bytes with FIFO_DEPTH=8 -> full=1, overflow=1, 9th byte lost. Then con_ready=1 -> 8 bytes drain in order, one per cycle. Write CON_STAT bit4 -> overflow=0.
- Read 0x2000_0000 with bus_re=1 -> bus_data_out=0 and no state change. With DMEM_RESP_FAULT_EN defined, bus_fault pulses high for one cycle.
